// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and width helpers for the two-requester multiplier arbiter.
package mult_share_arbiter_pkg;

  localparam int unsigned W_DEF         = 8;
  localparam int unsigned BUSY_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  function automatic int unsigned prod_width(input int unsigned w);
    return 2 * w;
  endfunction

  // Width of a counter that spans 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester and multiplier-side signals of the shared multiplier arbiter.
interface mult_share_arbiter_if
  import mult_share_arbiter_pkg::*;
#(
  parameter int unsigned W = W_DEF
);
  localparam int unsigned PW = prod_width(W);

  logic          r0_start;
  logic [W-1:0]  r0_a;
  logic [W-1:0]  r0_b;
  logic          r0_busy;
  logic          r0_done;
  logic [PW-1:0] r0_result;

  logic          r1_start;
  logic [W-1:0]  r1_a;
  logic [W-1:0]  r1_b;
  logic          r1_busy;
  logic          r1_done;
  logic [PW-1:0] r1_result;

  logic          mul_start;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [PW-1:0] mul_f;
  logic          mul_busy;

  logic          err;

  // Arbiter side.
  modport slave (
    input  r0_start, r0_a, r0_b, r1_start, r1_a, r1_b, mul_f, mul_busy,
    output r0_busy, r0_done, r0_result, r1_busy, r1_done, r1_result,
    output mul_start, mul_a, mul_b, err
  );

  // Requester / multiplier side.
  modport master (
    output r0_start, r0_a, r0_b, r1_start, r1_a, r1_b, mul_f, mul_busy,
    input  r0_busy, r0_done, r0_result, r1_busy, r1_done, r1_result,
    input  mul_start, mul_a, mul_b, err
  );

endinterface

// File: rtl/mult_share_arbiter_rr_grant2.sv
// Combinational two-way round-robin pick: favour the requester not granted last.
module rr_grant2 (
  input  logic [1:0] pending,
  input  logic       last_grant,
  output logic       valid_c,
  output logic       grant_c
);

  always_comb begin
    valid_c = |pending;
    grant_c = 1'b0;
    if (pending[~last_grant]) begin
      grant_c = ~last_grant;
    end else if (pending[last_grant]) begin
      grant_c = last_grant;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one start/busy sequential multiplier between two requesters, granting
// round-robin and returning each product on a per-requester done pulse.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned BUSY_WAIT = BUSY_WAIT_DEF
) (
  input logic                  clk,
  input logic                  rst,
  mult_share_arbiter_if.slave  bus
);

  localparam int unsigned PW = prod_width(W);
  localparam int unsigned CW = cnt_width(BUSY_WAIT);

  state_t             state;
  state_t             state_nxt;

  logic [1:0]         pending;
  logic               last_grant;
  logic               gnt;
  logic [1:0][W-1:0]  op_a;
  logic [1:0][W-1:0]  op_b;
  logic [CW-1:0]      wait_cnt;

  logic               mul_start;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic               err;
  logic [1:0]         done;
  logic [PW-1:0]      r0_result;
  logic [PW-1:0]      r1_result;

  logic               pick_valid;
  logic               pick;

  logic               issue;
  logic               timeout;
  logic               finish;
  logic               respond;
  logic               wait_last;

  rr_grant2 u_rr_grant2 (
    .pending    (pending),
    .last_grant (last_grant),
    .valid_c    (pick_valid),
    .grant_c    (pick)
  );

  assign wait_last = (wait_cnt == CW'(BUSY_WAIT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.mul_busy)   state_nxt = WAIT_DONE;
        else if (wait_last) state_nxt = IDLE;
      end
      WAIT_DONE: begin
        if (!bus.mul_busy) state_nxt = RESPOND;
      end
      RESPOND: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    issue   = 1'b0;
    timeout = 1'b0;
    finish  = 1'b0;
    respond = 1'b0;
    case (state)
      IDLE:      issue   = pick_valid;
      WAIT_BUSY: timeout = !bus.mul_busy && wait_last;
      WAIT_DONE: finish  = !bus.mul_busy;
      RESPOND:   respond = 1'b1;
      default: ;
    endcase
  end

  // Request capture, multiplier drive and result return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      wait_cnt   <= '0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      err        <= 1'b0;
      done       <= '0;
      r0_result  <= '0;
      r1_result  <= '0;
    end else begin
      mul_start <= issue;
      err       <= timeout;
      done[0]   <= respond && !gnt;
      done[1]   <= respond && gnt;

      // A start is only taken while that requester has nothing outstanding.
      if (bus.r0_start && !pending[0]) begin
        pending[0] <= 1'b1;
        op_a[0]    <= bus.r0_a;
        op_b[0]    <= bus.r0_b;
      end
      if (bus.r1_start && !pending[1]) begin
        pending[1] <= 1'b1;
        op_a[1]    <= bus.r1_a;
        op_b[1]    <= bus.r1_b;
      end

      if (issue) begin
        gnt      <= pick;
        mul_a    <= op_a[pick];
        mul_b    <= op_b[pick];
        wait_cnt <= '0;
      end else if (state == WAIT_BUSY) begin
        wait_cnt <= wait_cnt + CW'(1);
      end

      if (finish) begin
        if (gnt) r1_result <= bus.mul_f;
        else     r0_result <= bus.mul_f;
      end

      // A timed-out request is dropped without touching fairness history.
      if (timeout || respond) pending[gnt] <= 1'b0;
      if (respond)            last_grant   <= gnt;
    end
  end

  assign bus.mul_start = mul_start;
  assign bus.mul_a     = mul_a;
  assign bus.mul_b     = mul_b;
  assign bus.err       = err;
  assign bus.r0_busy   = pending[0];
  assign bus.r1_busy   = pending[1];
  assign bus.r0_done   = done[0];
  assign bus.r1_done   = done[1];
  assign bus.r0_result = r0_result;
  assign bus.r1_result = r1_result;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural start/busy multiplier.
module tb_mult_share_arbiter;
  import mult_share_arbiter_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned BW = 4;
  localparam int unsigned PW = 2 * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_share_arbiter_if #(.W(W)) bus ();

  mult_share_arbiter #(.W(W), .BUSY_WAIT(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Multiplier model: busy for lat cycles, junk on mul_f until it finishes.
  int            lat   = 3;
  bit            stall = 1'b0;
  logic          sbusy;
  int            scnt;
  logic [W-1:0]  sa, sb;
  logic [PW-1:0] sf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbusy <= 1'b0; scnt <= 0; sa <= '0; sb <= '0; sf <= '0;
    end else if (sbusy) begin
      if (scnt <= 1) begin
        sbusy <= 1'b0;
        sf    <= PW'(sa) * PW'(sb);
      end else begin
        scnt <= scnt - 1;
        sf   <= PW'($urandom);
      end
    end else if (bus.mul_start && !stall) begin
      sbusy <= 1'b1; scnt <= lat; sa <= bus.mul_a; sb <= bus.mul_b;
      sf    <= PW'($urandom);
    end
  end
  assign bus.mul_busy = sbusy;
  assign bus.mul_f    = sf;

  // Reference model: one outstanding request per requester, products in order.
  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];
  int            accepted[2] = '{0, 0};
  int            retired[2]  = '{0, 0};
  logic [PW-1:0] last_res[2] = '{'0, '0};
  int            n_issue     = 0;
  int            done_order[$];

  int since      = 100;
  int err_seen   = 0;
  int starts_seen = 0;
  int skip[2]    = '{0, 0};

  task automatic handle_done(input int n, input logic [PW-1:0] res, input logic busy_now);
    logic [PW-1:0] e;
    int o;
    o = 1 - n;
    if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
      checks++; errors++;
      $display("FAIL unexpected_done r%0d: got result %0h with nothing outstanding", n, res);
    end else begin
      e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk($sformatf("r%0d_result", n), 32'(res), 32'(e));
      chk($sformatf("r%0d_busy_at_done", n), 32'(busy_now), 32'd0);
      last_res[n] = res;
      retired[n]++;
      done_order.push_back(n);
      if (accepted[o] != retired[o]) skip[o]++;
      skip[n] = 0;
      chk($sformatf("r%0d_wait_bound", o), 32'(skip[o] <= 1), 32'd1);
    end
  endtask

  // Monitor: compares DUT responses against the model, one sample per cycle.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      since   = 100;
      skip[0] = 0;
      skip[1] = 0;
    end else begin
      if (bus.mul_start) begin
        starts_seen++;
        since = 0;
      end else begin
        since++;
      end
      if (sbusy) begin
        chk("mul_a_stable", 32'(bus.mul_a), 32'(sa));
        chk("mul_b_stable", 32'(bus.mul_b), 32'(sb));
      end
      if (bus.r0_done) handle_done(0, bus.r0_result, bus.r0_busy);
      if (bus.r1_done) handle_done(1, bus.r1_result, bus.r1_busy);
      if (bus.err) begin
        err_seen++;
        chk("err_delay", 32'(since), 32'(BW));
        chk("err_expected", 32'(stall), 32'd1);
        chk("busy_clear_on_err", 32'(bus.r0_busy | bus.r1_busy), 32'd0);
        chk("r0_result_kept", 32'(bus.r0_result), 32'(last_res[0]));
        if (accepted[0] != retired[0] && exp_q0.size() > 0) begin
          void'(exp_q0.pop_front()); retired[0]++;
        end else if (accepted[1] != retired[1] && exp_q1.size() > 0) begin
          void'(exp_q1.pop_front()); retired[1]++;
        end
      end
    end
  end

  task automatic drive(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin bus.r0_start = 1'b1; bus.r0_a = a; bus.r0_b = b; end
    else        begin bus.r1_start = 1'b1; bus.r1_a = a; bus.r1_b = b; end
    if (accepted[n] == retired[n]) begin
      if (n == 0) exp_q0.push_back(PW'(a) * PW'(b));
      else        exp_q1.push_back(PW'(a) * PW'(b));
      accepted[n]++;
      n_issue++;
    end
  endtask

  task automatic clr();
    bus.r0_start = 1'b0; bus.r1_start = 1'b0;
    bus.r0_a = W'($urandom); bus.r0_b = W'($urandom);
    bus.r1_a = W'($urandom); bus.r1_b = W'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((accepted[0] != retired[0] || accepted[1] != retired[1]) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", 32'(t < 300), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_r0_busy"},   32'(bus.r0_busy),   32'd0);
    chk({tag, "_r0_done"},   32'(bus.r0_done),   32'd0);
    chk({tag, "_r0_result"}, 32'(bus.r0_result), 32'd0);
    chk({tag, "_r1_busy"},   32'(bus.r1_busy),   32'd0);
    chk({tag, "_r1_done"},   32'(bus.r1_done),   32'd0);
    chk({tag, "_r1_result"}, 32'(bus.r1_result), 32'd0);
    chk({tag, "_mul_start"}, 32'(bus.mul_start), 32'd0);
    chk({tag, "_mul_ab"},    32'({bus.mul_a, bus.mul_b}), 32'd0);
    chk({tag, "_err"},       32'(bus.err),       32'd0);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    accepted[0] = retired[0];
    accepted[1] = retired[1];
    last_res[0] = '0;
    last_res[1] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_order(input string tag, input int e0, input int e1);
    int sz;
    sz = done_order.size();
    chk({tag, "_done_count"}, 32'(sz >= 2), 32'd1);
    if (sz >= 2) begin
      chk({tag, "_first"},  32'(done_order[sz-2]), 32'(e0));
      chk({tag, "_second"}, 32'(done_order[sz-1]), 32'(e1));
    end
  endtask

  initial begin
    int t;
    int n_done;
    rst = 1'b1;
    clr();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 3*5 alone, with mul_start one edge after capture.
    @(negedge clk);
    drive(0, 8'd3, 8'd5);
    @(posedge clk); #1;
    chk("t1_busy_rise", 32'(bus.r0_busy), 32'd1);
    chk("t1_no_early_start", 32'(bus.mul_start), 32'd0);
    @(negedge clk);
    clr();
    @(posedge clk); #1;
    chk("t1_mul_start", 32'(bus.mul_start), 32'd1);
    chk("t1_mul_ab", 32'({bus.mul_a, bus.mul_b}), 32'({8'd3, 8'd5}));
    drain();
    chk("t1_r1_result_untouched", 32'(bus.r1_result), 32'd0);
    chk("t1_one_start", 32'(starts_seen), 32'd1);

    // Simultaneous starts from reset: r0 first.
    do_reset();
    drive(0, 8'd7, 8'd9);
    drive(1, 8'd4, 8'd4);
    @(negedge clk);
    clr();
    drain();
    check_order("t2", 0, 1);

    // r1 arrives while r0 is being served.
    lat = 6;
    drive(0, 8'd10, 8'd11);
    @(negedge clk);
    clr();
    repeat (3) @(negedge clk);
    drive(1, 8'd12, 8'd13);
    @(negedge clk);
    clr();
    drain();
    check_order("t3", 0, 1);

    // Second r0 start while busy is dropped.
    lat = 3;
    n_done = done_order.size();
    drive(0, 8'd2, 8'd3);
    @(negedge clk);
    clr();
    repeat (2) @(negedge clk);
    drive(0, 8'd9, 8'd9);
    @(negedge clk);
    clr();
    drain();
    chk("t4_single_done", 32'(done_order.size() - n_done), 32'd1);

    // Multiplier never raises busy.
    stall = 1'b1;
    drive(0, 8'd11, 8'd3);
    @(negedge clk);
    clr();
    t = 0;
    while (err_seen == 0 && t < 40) begin @(negedge clk); t++; end
    chk("t5_err_seen", 32'(err_seen), 32'd1);
    chk("t5_r0_busy_clear", 32'(bus.r0_busy), 32'd0);
    repeat (4) @(negedge clk);
    stall = 1'b0;

    // Reset asserted while the multiplier is busy.
    lat = 10;
    drive(0, 8'd50, 8'd60);
    @(negedge clk);
    clr();
    t = 0;
    while (!sbusy && t < 20) begin @(negedge clk); t++; end
    chk("t6_mul_busy_seen", 32'(sbusy), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_zero("midrst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lat = 2;
    drive(0, 8'd2, 8'd2);
    @(negedge clk);
    clr();
    drain();
    chk("t6_fresh_result", 32'(bus.r0_result), 32'd4);

    // Random traffic, including starts while busy.
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(1, 5));
      if ($urandom_range(0, 2) == 0) drive(0, W'($urandom), W'($urandom));
      else bus.r0_start = 1'b0;
      if ($urandom_range(0, 2) == 0) drive(1, W'($urandom), W'($urandom));
      else bus.r1_start = 1'b0;
    end
    @(negedge clk);
    clr();
    drain();

    chk("total_mul_starts", 32'(starts_seen), 32'(n_issue));
    chk("total_errs", 32'(err_seen), 32'd1);
    chk("queues_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
